// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM encoding and the rotating-priority pick helper.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [ID_W-1:0]  ptr);
    pick_t           p;
    logic [ID_W-1:0] c;
    p = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = ptr + ID_W'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/decoder_2x4_en.sv
// 2-to-4 one-hot decoder with enable; output is all zeros when disabled.
module decoder_2x4_en
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]  i_sel,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with zero-bubble hand-off on release.
// Optional forced-release hold timer enabled by macro ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; grant the first requester from ptr
// GRANT | owner holds until done (or timeout); hand off or go idle
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
`ifdef ARB_TIMEOUT_EN
  , output logic           timeout
`endif
);

  state_t          r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, w_ptr_nxt;
  logic [ID_W-1:0] r_gnt_id, w_gnt_id_nxt;
  logic            w_enter;
  logic            w_release;
  logic            w_timeout;
  logic [N_REQ-1:0] w_req_masked;
  pick_t           w_pick;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_hold, w_hold_nxt;

  assign w_timeout = (r_state == GRANT) && !done && (r_hold == HOLD_MAX);
  assign timeout   = w_timeout;

  always_comb begin
    w_hold_nxt = r_hold;
    if (w_enter || (w_state_nxt == IDLE)) w_hold_nxt = '0;
    else if ((r_state == GRANT) && !done) w_hold_nxt = r_hold + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hold <= '0;
    else     r_hold <= w_hold_nxt;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // On release the owner is masked so it cannot immediately win again.
  assign w_release    = (r_state == GRANT) && (done || w_timeout);
  assign w_req_masked = (r_state == GRANT) ? (req & ~(N_REQ'(1) << r_gnt_id)) : req;
  assign w_pick       = rr_pick(w_req_masked, r_ptr);

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_id_nxt = r_gnt_id;
    w_enter      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = w_pick.idx;
          w_ptr_nxt    = w_pick.idx + ID_W'(1);
          w_enter      = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) begin
          if (w_pick.found) begin
            w_gnt_id_nxt = w_pick.idx;
            w_ptr_nxt    = w_pick.idx + ID_W'(1);
            w_enter      = 1'b1;
          end else begin
            w_state_nxt  = IDLE;
            w_gnt_id_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt_id <= w_gnt_id_nxt;
    end
  end

  assign gnt_valid = (r_state == GRANT);
  assign gnt_id    = r_gnt_id;

  decoder_2x4_en u_dec (
    .i_sel    (r_gnt_id),
    .i_en     (gnt_valid),
    .o_onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic against
// an integer-level round-robin model compared on every falling edge.
module tb_rr_arbiter_4;

`ifdef ARB_TIMEOUT_EN
  localparam int  TO_CYC = 4;
  localparam bit  TO_EN  = 1'b1;
  localparam int  HOLD_N = 2;
`else
  localparam int  TO_CYC = 16;
  localparam bit  TO_EN  = 1'b0;
  localparam int  HOLD_N = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout_w;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model state: owner -1 means idle
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    , .timeout (timeout_w)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout_w = 1'b0;
`endif

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic bit model_timeout();
    return TO_EN && (m_owner >= 0) && (m_hold == TO_CYC - 1) && !done;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      int w;
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % 4;
        m_hold  = 0;
      end
    end else if (done || model_timeout()) begin
      int w;
      logic [3:0] mreq;
      mreq = req;
      mreq[m_owner] = 1'b0;
      w = pick(mreq, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % 4;
      end else begin
        m_owner = -1;
      end
      m_hold = 0;
    end else begin
      m_hold = m_hold + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("model_gnt", int'(gnt), int'(eg));
      check("model_valid", int'(gnt_valid), int'(m_owner >= 0));
      if (m_owner >= 0) check("model_gnt_id", int'(gnt_id), m_owner);
      if (TO_EN) check("model_timeout", int'(timeout_w), int'(model_timeout()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #2;
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(gnt_valid), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_timeout", int'(timeout_w), 0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rot [5];
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
    rot[3] = 4'b1000; rot[4] = 4'b0001;

    do_reset();
    chk_en = 1'b1;

    // single requester, grant then release to idle
    req = 4'b0100;
    tick();
    check("s1_gnt", int'(gnt), 4);
    check("s1_id", int'(gnt_id), 2);
    check("s1_valid", int'(gnt_valid), 1);
    done = 1'b1;
    tick();
    check("s1_rel_gnt", int'(gnt), 0);
    check("s1_rel_valid", int'(gnt_valid), 0);
    done = 1'b0;
    req  = 4'b0000;

    // full rotation with done every cycle
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_rot_gnt", int'(gnt), int'(rot[i]));
      check("s2_rot_valid", int'(gnt_valid), 1);
    end
    done = 1'b0;
    req  = 4'b0000;

    // owner 1 holds despite req dropping
    do_reset();
    req = 4'b0010;
    tick();
    check("s3_gnt", int'(gnt), 2);
    req = 4'b0000;
    for (int i = 0; i < HOLD_N; i++) begin
      tick();
      check("s3_hold", int'(gnt), 2);
    end
    done = 1'b1;
    tick();
    check("s3_idle", int'(gnt_valid), 0);
    done = 1'b0;

    // wrap-around from owner 3 to requester 0
    do_reset();
    req = 4'b1000;
    tick();
    check("s4_owner3", int'(gnt), 8);
    req  = 4'b1001;
    done = 1'b1;
    tick();
    check("s4_wrap", int'(gnt), 1);
    check("s4_wrap_id", int'(gnt_id), 0);
    done = 1'b0;
    req  = 4'b0000;

    // async reset mid-grant
    do_reset();
    req = 4'b0100;
    tick();
    check("s5_pre", int'(gnt), 4);
    #2 rst = 1'b1;
    #1;
    check("s5_async_gnt", int'(gnt), 0);
    check("s5_async_valid", int'(gnt_valid), 0);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    check("s5_after", int'(gnt), 2);
    req = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // forced release after TO_CYC cycles
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < TO_CYC; i++) begin
      tick();
      check("s6_owner0", int'(gnt), 1);
      #3;
      check("s6_timeout", int'(timeout_w), int'(i == TO_CYC - 1));
    end
    tick();
    check("s6_next", int'(gnt), 2);
    check("s6_pulse_end", int'(timeout_w), 0);
    req = 4'b0000;
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 9) < 3);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles one grant may be held (used only with ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: one request line per requester; bit i is requester i.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the resource in this cycle.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant; all zeros when no grant is active.
REQ-007 The block SHALL have port gnt_id, output, 2 bits: the binary index of the current owner.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release; the port exists only with ARB_TIMEOUT_EN.

Function
REQ-010 The block SHALL implement a two-state machine with states IDLE and GRANT.
REQ-011 In IDLE, if req is nonzero, the block SHALL select a requester, enter GRANT and assert gnt_valid on the next rising edge (latency 1 cycle).
REQ-012 Selection SHALL be round-robin:
- The search starts at index ptr and proceeds ptr, ptr+1, ... modulo 4.
- The first set req bit wins.
REQ-013 The pointer ptr SHALL be set to (winner+1) mod 4 on every new grant, wrapping from 3 to 0.
REQ-014 gnt SHALL equal the 2-to-4 decode of gnt_id, enabled by gnt_valid; gnt is 4'b0000 whenever gnt_valid is 0.
REQ-015 In GRANT, gnt, gnt_id and ptr SHALL be held unchanged until a release event.
- Changes on req, including the owner's own req bit, SHALL NOT affect the grant; only a release ends it.
REQ-016 A release event SHALL be done=1 in GRANT.
- With ARB_TIMEOUT_EN, a forced timeout is also a release event.
- done=1 in IDLE SHALL be ignored.
REQ-017 On a release event, if req with the owner bit masked is nonzero, the block SHALL grant the next requester on the same edge with zero bubble and stay in GRANT.
- Otherwise the block SHALL return to IDLE, clearing gnt_valid and gnt.
REQ-018 Owner masking SHALL apply only on the release cycle; in IDLE, a former owner is eligible again under the normal pointer order.
REQ-019 If req is 4'b1111 continuously and done pulses every cycle, grants SHALL rotate 0,1,2,3,0, ... with no repetition and no gap.

Reset
REQ-020 While rst=1, the outputs SHALL be held asynchronously at:
- state=IDLE, ptr=0
- gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0
- hold counter=0
REQ-021 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-022 The first grant after reset deassertion SHALL follow the priority order starting at requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: behaviour SHALL be as follows.
- A hold counter clears on entry to GRANT and increments every GRANT cycle without done.
- When the counter reaches TIMEOUT_CYCLES-1 with done=0, the block SHALL force a release per REQ-017.
- The timeout port SHALL pulse high for that one cycle.
- The counter SHALL be sized to represent TIMEOUT_CYCLES-1 without overflow.
REQ-024 Macro ARB_TIMEOUT_EN undefined: the block SHALL have no counter and no timeout port, and a grant SHALL be held indefinitely until done.

Structure
REQ-025 A shared package arb_pkg SHALL hold the state encodings IDLE=1'b0 and GRANT=1'b1 and the constants N_REQ=4 and ID_W=2.
REQ-026 The block SHALL contain one sub-module, decoder_2x4_en, a 2-to-4 decoder with enable that generates gnt from gnt_id and gnt_valid.

Verification
REQ-027 The bench SHALL cover the following directed scenarios.
- Reset then req=4'b0100 → next edge gnt=4'b0100, gnt_id=2, gnt_valid=1; done=1 → next edge gnt=4'b0000, gnt_valid=0.
- req=4'b1111, done=1 every cycle → gnt sequence 0001, 0010, 0100, 1000, 0001, with gnt_valid continuously 1.
- Owner 1 holding, req changes to 4'b0000 with done=0 → gnt stays 4'b0010 for 10 cycles; done=1 → IDLE next edge.
- Owner 3, done=1 with req=4'b1001 → next edge grant goes to 0 (wrap-around), never back to 3.
- Grant active, rst pulses mid-cycle → gnt=4'b0000 immediately, with no clock edge needed; after release req=4'b1010 → gnt=4'b0010.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, req=4'b0011, done held 0 → owner 0 for 4 cycles, timeout pulse on the 4th cycle, next edge gnt=4'b0010.
